conway_life_engine: RTL and testbench
=====================================

// Module: conway_life_engine
// PURPOSE
//   Parametrised life-like cellular automaton engine. Holds a ROWS x COLS cell grid and
//   evolves it by a programmable birth/survive rule, one generation per clock, for a
//   requested number of generations. Supports toroidal or dead-boundary edges, a
//   generation counter, and still-life and extinction detection.
// PARAMETERS
//   ROWS  16  grid rows (>=3)
//   COLS  16  grid columns (>=3)
//   WRAP  1   1: toroidal edges; 0: off-grid neighbours count as dead
//   GEN_W 16  width of num_gens and gen_count
// PORTS
//   clk          in   1          rising-edge clock
//   rst_n        in   1          async active-low reset
//   load         in   1          load grid from data (priority over all else)
//   data         in   ROWS*COLS  grid image; cell (r,c) = bit r*COLS+c
//   birth_mask   in   9          bit n=1: dead cell with n live neighbours is born
//   survive_mask in   9          bit n=1: live cell with n live neighbours survives
//   start        in   1          begin run of num_gens generations (accepted in IDLE only)
//   num_gens     in   GEN_W      generations to run; sampled with start
//   stop_stable  in   1          1: end run early on still life; sampled with start
//   busy         out  1          high in RUN
//   done         out  1          one-cycle pulse at end of run
//   q            out  ROWS*COLS  current grid
//   gen_count    out  GEN_W      generations applied since last load; saturates at all-ones
//   stable       out  1          last applied generation left q unchanged
//   extinct      out  1          combinational: q == 0
// BEHAVIOUR
//   Reset: q=0, gen_count=0, busy=0, done=0, stable=0; FSM=IDLE. Masks and remaining count cleared.
//   Neighbours of (r,c): the 8 cells at r+-1, c+-1. WRAP=1: indices mod ROWS/COLS.
//     WRAP=0: out-of-range cells contribute 0. Count n is 0..8 (4 bits).
//   next(r,c) = q(r,c) ? survive_mask_l[n] : birth_mask_l[n]. Uses masks latched at start.
//   FSM IDLE:
//     load=1: q<=data, gen_count<=0, stable<=0; stay IDLE.
//     start=1 & num_gens=0: no evolution; done=1 on the next cycle.
//     start=1 & num_gens>0: latch masks, stop_stable, remaining<=num_gens; ->RUN.
//   FSM RUN (busy=1), per cycle:
//     q<=next(q); gen_count++ (saturating); stable<=(next(q)==q); remaining--.
//     Exit to IDLE with done=1 the following cycle when either:
//       remaining==1, or stop_stable_l & next(q)==q.
//     The generation that detects stability is still counted.
//     start is ignored while in RUN.
//   Priorities: load in RUN aborts the run: q<=data, gen_count<=0, stable<=0, ->IDLE.
//     No done pulse is issued on abort. load and start in the same cycle: load wins,
//     start is dropped.
//   Latency: run of N generations with no early stop gives done N cycles after start is accepted.
//     On the done cycle q holds generation N.
//   extinct does not stop a run. An all-dead grid under B0 rules may be reborn.
//   Async reset mid-run forces the reset state immediately. No done pulse is issued.
// TESTING
//   1. 16x16 WRAP=1, B3/S23 (birth=9'h008, survive=9'h00C), blinker at rows 5-7 col 5, N=2
//      -> q after gen1 is horizontal; done at cycle 2; q equals load image; gen_count=2.
//   2. Glider near corner (wraps edges), N=64 -> q equals load image; stable=0; gen_count=64.
//   3. 2x2 block, stop_stable=1, N=100 -> done after 1 generation; gen_count=1; stable=1.
//   4. WRAP=0, blinker on column 0 vs WRAP=1 -> results differ. WRAP=0 image matches golden model with dead border.
//   5. HighLife B36/S23 (birth=9'h048) random seed, N=20 -> bit-exact vs software model each gen.
//   6. load at cycle 3 of N=10 run -> q=data, gen_count=0, no done. rst_n low mid-run -> all outputs 0.
//      num_gens=0 -> done next cycle, q unchanged.

Source files
------------

// File: rtl/conway_life_engine.sv
// conway_life_engine
// Life-like cellular automaton engine. Holds a ROWS x COLS grid and advances it
// one generation per clock under a programmable birth/survive rule, for a
// requested number of generations. Edges are either toroidal (WRAP=1) or dead
// (WRAP=0). Reports a saturating generation count, still-life and extinction.

module conway_life_engine #(
  parameter int ROWS  = 16,
  parameter int COLS  = 16,
  parameter int WRAP  = 1,
  parameter int GEN_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load,
  input  logic [ROWS*COLS-1:0] data,
  input  logic [8:0]           birth_mask,
  input  logic [8:0]           survive_mask,
  input  logic                 start,
  input  logic [GEN_W-1:0]     num_gens,
  input  logic                 stop_stable,
  output logic                 busy,
  output logic                 done,
  output logic [ROWS*COLS-1:0] q,
  output logic [GEN_W-1:0]     gen_count,
  output logic                 stable,
  output logic                 extinct
);

  localparam int CELLS = ROWS * COLS;
  localparam logic [GEN_W-1:0] GEN_ONE = {{(GEN_W-1){1'b0}}, 1'b1};

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [0:0]       state;
  logic [8:0]       birth_l;
  logic [8:0]       survive_l;
  logic             stop_stable_l;
  logic [GEN_W-1:0] remaining;
  logic [CELLS-1:0] next_grid;
  logic             grid_same;
  logic             run_last;

  // Per-cell neighbour gathering and rule lookup. Neighbour positions are
  // resolved at elaboration time, so dead-border cells simply tie to zero.
  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      logic [7:0] nb;
      logic [3:0] n;

      for (genvar k = 0; k < 8; k++) begin : g_nb
        localparam int DR = (k < 3) ? -1 : ((k < 5) ? 0 : 1);
        localparam int DC = (k == 0 || k == 3 || k == 5) ? -1 :
                            ((k == 1 || k == 6) ? 0 : 1);
        localparam int RR = (WRAP != 0) ? (r + DR + ROWS) % ROWS : r + DR;
        localparam int CC = (WRAP != 0) ? (c + DC + COLS) % COLS : c + DC;
        localparam bit INSIDE = (RR >= 0) && (RR < ROWS) && (CC >= 0) && (CC < COLS);
        if (INSIDE) begin : g_in
          assign nb[k] = q[RR*COLS + CC];
        end else begin : g_out
          assign nb[k] = 1'b0;
        end
      end

      // Live-neighbour count, 0..8.
      always_comb begin
        n = 4'd0;
        for (int k = 0; k < 8; k++) begin
          n = n + {3'b000, nb[k]};
        end
      end

      assign next_grid[r*COLS + c] = q[r*COLS + c] ? survive_l[n] : birth_l[n];
    end
  end

  assign grid_same = (next_grid == q);
  assign run_last  = (remaining == GEN_ONE) || (stop_stable_l && grid_same);
  assign busy      = (state == S_RUN);
  assign extinct   = (q == '0);

  // Run control: accepts start in IDLE, counts generations down in RUN and
  // emits a one-cycle done after the final generation. load aborts silently.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      done          <= 1'b0;
      birth_l       <= '0;
      survive_l     <= '0;
      stop_stable_l <= 1'b0;
      remaining     <= '0;
    end else begin
      done <= 1'b0;
      if (load) begin
        state <= S_IDLE;
      end else begin
        case (state)
          S_IDLE: begin
            if (start) begin
              if (num_gens == '0) begin
                done <= 1'b1;
              end else begin
                birth_l       <= birth_mask;
                survive_l     <= survive_mask;
                stop_stable_l <= stop_stable;
                remaining     <= num_gens;
                state         <= S_RUN;
              end
            end
          end
          S_RUN: begin
            remaining <= remaining - GEN_ONE;
            if (run_last) begin
              state <= S_IDLE;
              done  <= 1'b1;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  // Grid, generation counter and still-life flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q         <= '0;
      gen_count <= '0;
      stable    <= 1'b0;
    end else if (load) begin
      q         <= data;
      gen_count <= '0;
      stable    <= 1'b0;
    end else if (state == S_RUN) begin
      q      <= next_grid;
      stable <= grid_same;
      if (gen_count != '1) begin
        gen_count <= gen_count + GEN_ONE;
      end
    end
  end

endmodule

// File: tb/tb_conway_life_engine.sv
// Directed testbench for conway_life_engine: a toroidal 16x16 instance and a
// dead-border 16x16 instance share all inputs.

module tb_conway_life_engine;

  logic         clk;
  logic         rst_n;
  logic         load;
  logic [255:0] data;
  logic [8:0]   birth_mask;
  logic [8:0]   survive_mask;
  logic         start;
  logic [15:0]  num_gens;
  logic         stop_stable;

  logic         busy, done, stable, extinct;
  logic [255:0] q;
  logic [15:0]  gen_count;
  logic         busy_nw, done_nw, stable_nw, extinct_nw;
  logic [255:0] q_nw;
  logic [15:0]  gen_count_nw;

  int passed = 0;
  int total  = 0;

  localparam logic [8:0] B3  = 9'h008;
  localparam logic [8:0] B36 = 9'h048;
  localparam logic [8:0] S23 = 9'h00C;

  conway_life_engine #(.ROWS(16), .COLS(16), .WRAP(1), .GEN_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .data(data),
    .birth_mask(birth_mask), .survive_mask(survive_mask),
    .start(start), .num_gens(num_gens), .stop_stable(stop_stable),
    .busy(busy), .done(done), .q(q), .gen_count(gen_count),
    .stable(stable), .extinct(extinct)
  );

  conway_life_engine #(.ROWS(16), .COLS(16), .WRAP(0), .GEN_W(16)) dut_nw (
    .clk(clk), .rst_n(rst_n), .load(load), .data(data),
    .birth_mask(birth_mask), .survive_mask(survive_mask),
    .start(start), .num_gens(num_gens), .stop_stable(stop_stable),
    .busy(busy_nw), .done(done_nw), .q(q_nw), .gen_count(gen_count_nw),
    .stable(stable_nw), .extinct(extinct_nw)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Software reference: one generation on a 16x16 grid.
  function automatic logic [255:0] life_step(input logic [255:0] g, input logic [8:0] b,
                                             input logic [8:0] s, input bit wrap);
    logic [255:0] nx;
    logic [7:0]   ix;
    logic [3:0]   nn;
    int n, rr, cc;
    nx = '0;
    for (int r = 0; r < 16; r++) begin
      for (int c = 0; c < 16; c++) begin
        n = 0;
        for (int dr = -1; dr <= 1; dr++) begin
          for (int dc = -1; dc <= 1; dc++) begin
            if (dr == 0 && dc == 0) continue;
            rr = r + dr;
            cc = c + dc;
            if (wrap) begin
              rr = (rr + 16) % 16;
              cc = (cc + 16) % 16;
            end
            if (rr >= 0 && rr < 16 && cc >= 0 && cc < 16) begin
              ix = 8'(rr * 16 + cc);
              if (g[ix]) n++;
            end
          end
        end
        nn = 4'(n);
        ix = 8'(r * 16 + c);
        nx[ix] = g[ix] ? s[nn] : b[nn];
      end
    end
    return nx;
  endfunction

  task automatic do_load(input logic [255:0] img);
    data = img;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  // Returns at the negedge following the accepting posedge.
  task automatic start_run(input logic [15:0] n, input logic [8:0] b, input logic [8:0] s,
                           input logic ss);
    birth_mask   = b;
    survive_mask = s;
    num_gens     = n;
    stop_stable  = ss;
    start        = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int cycles, output bit ok);
    cycles = 0;
    ok     = 1'b0;
    while (cycles <= budget) begin
      if (done) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
      cycles++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; load = 1'b0; start = 1'b0; data = '0; num_gens = '0;
    birth_mask = '0; survive_mask = '0; stop_stable = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (q !== 256'd0) $display("FAIL reset_q q=%h exp=0", q); else passed++;
    total++; if (gen_count !== 16'd0) $display("FAIL reset_gen got=%0d exp=0", gen_count); else passed++;
    total++; if ({busy, done, stable} !== 3'b000) $display("FAIL reset_ctl busy/done/stable=%b exp=000", {busy, done, stable}); else passed++;
    total++; if (extinct !== 1'b1) $display("FAIL reset_extinct got=%b exp=1", extinct); else passed++;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_blinker;
    logic [255:0] img, hor;
    int cyc; bit ok;
    img = '0; img[85] = 1'b1; img[101] = 1'b1; img[117] = 1'b1;
    hor = '0; hor[100] = 1'b1; hor[101] = 1'b1; hor[102] = 1'b1;
    do_load(img);
    total++; if (q !== img) $display("FAIL blink_load q=%h exp=%h", q, img); else passed++;
    start_run(16'd2, B3, S23, 1'b0);
    total++; if ({busy, done} !== 2'b10) $display("FAIL blink_busy busy/done=%b exp=10", {busy, done}); else passed++;
    @(negedge clk);
    total++; if (q !== hor) $display("FAIL blink_gen1 q=%h exp=%h", q, hor); else passed++;
    total++; if (done !== 1'b0) $display("FAIL blink_early_done got=%b exp=0", done); else passed++;
    wait_done(4, cyc, ok);
    total++; if (!ok || cyc != 1) $display("FAIL blink_latency ok=%0d cycles_after_gen1=%0d exp=1", ok, cyc); else passed++;
    total++; if (q !== img) $display("FAIL blink_gen2 q=%h exp=%h", q, img); else passed++;
    total++; if (gen_count !== 16'd2) $display("FAIL blink_gen_count got=%0d exp=2", gen_count); else passed++;
    total++; if ({busy, stable} !== 2'b00) $display("FAIL blink_end busy/stable=%b exp=00", {busy, stable}); else passed++;
    @(negedge clk);
    total++; if (done !== 1'b0) $display("FAIL blink_done_pulse got=%b exp=0", done); else passed++;
  endtask

  task automatic test_glider;
    logic [255:0] img, sh4;
    int cyc; bit ok;
    img = '0; img[239] = 1'b1; img[240] = 1'b1; img[14] = 1'b1; img[15] = 1'b1; img[0] = 1'b1;
    sh4 = '0; sh4[240] = 1'b1; sh4[1] = 1'b1; sh4[31] = 1'b1; sh4[16] = 1'b1; sh4[17] = 1'b1;
    do_load(img);
    start_run(16'd64, B3, S23, 1'b0);
    repeat (4) @(negedge clk);
    total++; if (q !== sh4) $display("FAIL glider_gen4 q=%h exp=%h", q, sh4); else passed++;
    repeat (6) @(negedge clk);
    num_gens = 16'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    total++; if (busy !== 1'b1) $display("FAIL glider_start_ignored busy=%b exp=1", busy); else passed++;
    wait_done(80, cyc, ok);
    total++; if (!ok || cyc + 11 != 64) $display("FAIL glider_latency ok=%0d cycles=%0d exp=64", ok, cyc + 11); else passed++;
    total++; if (q !== img) $display("FAIL glider_gen64 q=%h exp=%h", q, img); else passed++;
    total++; if (stable !== 1'b0) $display("FAIL glider_stable got=%b exp=0", stable); else passed++;
    total++; if (gen_count !== 16'd64) $display("FAIL glider_gen_count got=%0d exp=64", gen_count); else passed++;
  endtask

  task automatic test_block;
    logic [255:0] img;
    int cyc; bit ok;
    img = '0; img[51] = 1'b1; img[52] = 1'b1; img[67] = 1'b1; img[68] = 1'b1;
    do_load(img);
    start_run(16'd100, B3, S23, 1'b1);
    wait_done(110, cyc, ok);
    total++; if (!ok || cyc != 1) $display("FAIL block_latency ok=%0d cycles=%0d exp=1", ok, cyc); else passed++;
    total++; if (gen_count !== 16'd1) $display("FAIL block_gen_count got=%0d exp=1", gen_count); else passed++;
    total++; if (stable !== 1'b1) $display("FAIL block_stable got=%b exp=1", stable); else passed++;
    total++; if (q !== img) $display("FAIL block_q q=%h exp=%h", q, img); else passed++;
  endtask

  task automatic test_wrap_vs_dead;
    logic [255:0] img, exp_w, exp_d;
    int cyc; bit ok;
    img   = '0; img[80] = 1'b1; img[96] = 1'b1; img[112] = 1'b1;
    exp_w = '0; exp_w[111] = 1'b1; exp_w[96] = 1'b1; exp_w[97] = 1'b1;
    exp_d = '0; exp_d[96] = 1'b1; exp_d[97] = 1'b1;
    do_load(img);
    start_run(16'd1, B3, S23, 1'b0);
    wait_done(4, cyc, ok);
    total++; if (!ok || cyc != 1) $display("FAIL edge_latency ok=%0d cycles=%0d exp=1", ok, cyc); else passed++;
    total++; if (q !== exp_w) $display("FAIL edge_wrap q=%h exp=%h", q, exp_w); else passed++;
    total++; if (q_nw !== exp_d) $display("FAIL edge_dead q=%h exp=%h", q_nw, exp_d); else passed++;
    total++; if (q_nw !== life_step(img, B3, S23, 1'b0)) $display("FAIL edge_dead_model q=%h", q_nw); else passed++;
    total++; if (q_nw === q) $display("FAIL edge_differ both q=%h", q); else passed++;
    total++; if ({done_nw, busy_nw, stable_nw, extinct_nw} !== 4'b1000) $display("FAIL edge_dead_flags done/busy/stable/extinct=%b exp=1000", {done_nw, busy_nw, stable_nw, extinct_nw}); else passed++;
    total++; if (gen_count_nw !== 16'd1) $display("FAIL edge_dead_gen got=%0d exp=1", gen_count_nw); else passed++;
  endtask

  task automatic test_highlife;
    logic [255:0] seed, exp_w, exp_d;
    int bad_w, bad_d;
    for (int i = 0; i < 8; i++) seed[i*32 +: 32] = $urandom();
    do_load(seed);
    start_run(16'd20, B36, S23, 1'b0);
    exp_w = seed; exp_d = seed; bad_w = 0; bad_d = 0;
    for (int g = 1; g <= 20; g++) begin
      @(negedge clk);
      exp_w = life_step(exp_w, B36, S23, 1'b1);
      exp_d = life_step(exp_d, B36, S23, 1'b0);
      total++; if (q !== exp_w) begin $display("FAIL highlife_wrap gen=%0d q=%h exp=%h", g, q, exp_w); bad_w++; end else passed++;
      total++; if (q_nw !== exp_d) begin $display("FAIL highlife_dead gen=%0d q=%h exp=%h", g, q_nw, exp_d); bad_d++; end else passed++;
    end
    total++; if (done !== 1'b1) $display("FAIL highlife_done got=%b exp=1", done); else passed++;
    total++; if (gen_count !== 16'd20) $display("FAIL highlife_gen got=%0d exp=20", gen_count); else passed++;
  endtask

  task automatic test_abort;
    logic [255:0] gl, bl, blk;
    bit seen;
    gl  = '0; gl[239] = 1'b1; gl[240] = 1'b1; gl[14] = 1'b1; gl[15] = 1'b1; gl[0] = 1'b1;
    bl  = '0; bl[85] = 1'b1; bl[101] = 1'b1; bl[117] = 1'b1;
    blk = '0; blk[51] = 1'b1; blk[52] = 1'b1; blk[67] = 1'b1; blk[68] = 1'b1;
    do_load(gl);
    start_run(16'd10, B3, S23, 1'b0);
    repeat (2) @(negedge clk);
    do_load(bl);
    total++; if (q !== bl) $display("FAIL abort_q q=%h exp=%h", q, bl); else passed++;
    total++; if (gen_count !== 16'd0) $display("FAIL abort_gen got=%0d exp=0", gen_count); else passed++;
    total++; if ({busy, stable, done} !== 3'b000) $display("FAIL abort_ctl busy/stable/done=%b exp=000", {busy, stable, done}); else passed++;
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    total++; if (seen !== 1'b0) $display("FAIL abort_no_done seen=%b exp=0", seen); else passed++;
    // load and start together: load wins, start dropped
    data = blk; load = 1'b1; start = 1'b1; num_gens = 16'd5;
    @(negedge clk);
    load = 1'b0; start = 1'b0;
    total++; if (busy !== 1'b0) $display("FAIL load_start_busy got=%b exp=0", busy); else passed++;
    total++; if (q !== blk) $display("FAIL load_start_q q=%h exp=%h", q, blk); else passed++;
    @(negedge clk);
    total++; if ({busy, done} !== 2'b00) $display("FAIL load_start_dropped busy/done=%b exp=00", {busy, done}); else passed++;
  endtask

  task automatic test_zero_gens;
    logic [255:0] blk;
    blk = '0; blk[51] = 1'b1; blk[52] = 1'b1; blk[67] = 1'b1; blk[68] = 1'b1;
    start_run(16'd0, B3, S23, 1'b0);
    total++; if ({done, busy} !== 2'b10) $display("FAIL zero_done done/busy=%b exp=10", {done, busy}); else passed++;
    total++; if (q !== blk) $display("FAIL zero_q q=%h exp=%h", q, blk); else passed++;
    total++; if (gen_count !== 16'd0) $display("FAIL zero_gen got=%0d exp=0", gen_count); else passed++;
    @(negedge clk);
    total++; if (done !== 1'b0) $display("FAIL zero_pulse got=%b exp=0", done); else passed++;
  endtask

  task automatic test_reset_midrun;
    logic [255:0] bl;
    bl = '0; bl[85] = 1'b1; bl[101] = 1'b1; bl[117] = 1'b1;
    do_load(bl);
    start_run(16'd10, B3, S23, 1'b0);
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    total++; if (q !== 256'd0) $display("FAIL midreset_q q=%h exp=0", q); else passed++;
    total++; if (gen_count !== 16'd0) $display("FAIL midreset_gen got=%0d exp=0", gen_count); else passed++;
    total++; if ({busy, done, stable, extinct} !== 4'b0001) $display("FAIL midreset_ctl busy/done/stable/extinct=%b exp=0001", {busy, done, stable, extinct}); else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    total++; if ({busy, done} !== 2'b00) $display("FAIL midreset_after busy/done=%b exp=00", {busy, done}); else passed++;
  endtask

  task automatic test_b0_rebirth;
    logic [255:0] ones;
    int cyc; bit ok;
    ones = '1;
    do_load(256'd0);
    total++; if (extinct !== 1'b1) $display("FAIL b0_extinct_before got=%b exp=1", extinct); else passed++;
    start_run(16'd1, 9'h001, 9'h000, 1'b0);
    wait_done(4, cyc, ok);
    total++; if (!ok || cyc != 1) $display("FAIL b0_latency ok=%0d cycles=%0d exp=1", ok, cyc); else passed++;
    total++; if (q !== ones) $display("FAIL b0_reborn q=%h exp=%h", q, ones); else passed++;
    total++; if (extinct !== 1'b0) $display("FAIL b0_extinct_after got=%b exp=0", extinct); else passed++;
  endtask

  initial begin
    test_reset();
    test_blinker();
    test_glider();
    test_block();
    test_wrap_vs_dead();
    test_highlife();
    test_abort();
    test_zero_gens();
    test_reset_midrun();
    test_b0_rebirth();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout passed=%0d total=%0d", passed, total);
    $fatal(1, "watchdog");
  end

endmodule
